// File: rtl/fsm_ram_pkg.sv
// Shared types and constants for the register-image RAM FSMs (init and read side).
// Position-search helper is used by fsm_lect_ram when FSM_LECT_RAM_MASK_EN is defined.
package fsm_ram_pkg;

   localparam int N_POS  = 32;
   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ADDR = 3'd1,
      ST_CAPT = 3'd2,
      ST_PRES = 3'd3,
      ST_DONE = 3'd4
   } state_t;

   localparam logic [4:0] POS_ST0  = 5'd0;
   localparam logic [4:0] POS_SEG  = 5'd3;
   localparam logic [4:0] POS_MIN  = 5'd4;
   localparam logic [4:0] POS_HORA = 5'd5;
   localparam logic [4:0] POS_DIA  = 5'd6;
   localparam logic [4:0] POS_MES  = 5'd7;
   localparam logic [4:0] POS_ANIO = 5'd8;

   // Lowest set bit of m at index >= from; returns N_POS when there is none.
   function automatic logic [5:0] next_set(input logic [N_POS-1:0] m, input logic [5:0] from);
      logic [5:0] res;
      res = 6'(N_POS);
      for (int i = N_POS-1; i >= 0; i--)
         if (m[i] && (6'(i) >= from)) res = 6'(i);
      return res;
   endfunction

endpackage

// File: rtl/dec_onehot_5a32.sv
// 5-bit index to 32-bit one-hot decoder with enable; all zeros when disabled.
module dec_onehot_5a32 (
   input  logic        en_i,
   input  logic [4:0]  idx_i,
   output logic [31:0] onehot_o
);

   assign onehot_o = en_i ? (32'd1 << idx_i) : 32'd0;

endmodule

// File: rtl/fsm_lect_ram.sv
// Sweeps the 32 register-image RAM positions and hands each byte over valid/ready.
// Optional FSM_LECT_RAM_MASK_EN adds lect_mask to skip positions.
module fsm_lect_ram
   import fsm_ram_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              do_it_lect_ram,
`ifdef FSM_LECT_RAM_MASK_EN
   input  logic [N_POS-1:0]  lect_mask,
`endif
   input  logic [DATA_W-1:0] dato_ram,
   output logic [N_POS-1:0]  dir_ram,
   output logic              r_ram_enable,
   output logic              w_ram_enable,
   output logic [DATA_W-1:0] dato_out,
   output logic [4:0]        dir_pos,
   output logic              dato_valid,
   input  logic              dato_ready,
   output logic              busy,
   output logic              done
);

   state_t              state_q;
   logic [4:0]          cnt_q;
   logic                ren_q;
   logic [DATA_W-1:0]   dato_q;
   logic [4:0]          pos_q;
   logic                vld_q;
   logic                busy_q;
   logic                done_q;
   logic [5:0]          first_d;   // bit 5 set means no position to read
   logic [5:0]          nxt_d;

`ifdef FSM_LECT_RAM_MASK_EN
   logic [N_POS-1:0]    mask_q;
   assign first_d = next_set(lect_mask, 6'd0);
   assign nxt_d   = next_set(mask_q, {1'b0, cnt_q} + 6'd1);
`else
   assign first_d = 6'd0;
   assign nxt_d   = {1'b0, cnt_q} + 6'd1;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= 5'd0;
         ren_q   <= 1'b0;
         dato_q  <= '0;
         pos_q   <= 5'd0;
         vld_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef FSM_LECT_RAM_MASK_EN
         mask_q  <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (do_it_lect_ram) begin
                  busy_q <= 1'b1;
`ifdef FSM_LECT_RAM_MASK_EN
                  mask_q <= lect_mask;
`endif
                  if (first_d[5]) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_ADDR;
                     cnt_q   <= first_d[4:0];
                     ren_q   <= 1'b1;
                  end
               end
            end
            ST_ADDR: begin
               ren_q   <= 1'b0;
               state_q <= ST_CAPT;
            end
            ST_CAPT: begin
               dato_q  <= dato_ram;
               pos_q   <= cnt_q;
               vld_q   <= 1'b1;
               state_q <= ST_PRES;
            end
            ST_PRES: begin
               // Terminal test comes before the increment, so the counter never wraps.
               if (dato_ready) begin
                  vld_q <= 1'b0;
                  if (cnt_q == 5'(N_POS-1) || nxt_d[5]) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     cnt_q   <= nxt_d[4:0];
                     ren_q   <= 1'b1;
                     state_q <= ST_ADDR;
                  end
               end
            end
            ST_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
               ren_q   <= 1'b0;
               vld_q   <= 1'b0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   dec_onehot_5a32 u_dec (
      .en_i     (ren_q),
      .idx_i    (cnt_q),
      .onehot_o (dir_ram)
   );

   assign r_ram_enable = ren_q;
   assign w_ram_enable = 1'b0;
   assign dato_out     = dato_q;
   assign dir_pos      = pos_q;
   assign dato_valid   = vld_q;
   assign busy         = busy_q;
   assign done         = done_q;

endmodule
